cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Synthesizable run controller for CPU bring-up. It sits between the board or bench clock/reset and the CPU core. It stretches and releases the CPU reset, then runs the core in free-run or single-step mode. It ends the run on a halt flag, a PC-stall watchdog, or a cycle budget, and reports cycle count and termination cause.

Parameters:
PC_W, 32, width of the observed CPU program counter
CNT_W, 32, width of the cycle counter
RST_HOLD, 4, number of cycles cpu_rst is held after start (>=1)
MAX_CYCLES, 1000, cycle budget in enabled CPU cycles (< 2^CNT_W)
WDOG_CYCLES, 16, consecutive enabled cycles with unchanged PC that count as a stall; 0 disables the watchdog

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  level; starts a run from IDLE or DONE
mode  in  1  0 = free-run, 1 = single-step
step_req  in  1  single-step request; each rising edge gives one enabled cycle
cpu_halt  in  1  halt flag from the CPU core
cpu_pc  in  PC_W  current CPU program counter
cpu_rst  out  1  active-high reset to the CPU core
cpu_ce  out  1  CPU clock enable
busy  out  1  high in HOLD and RUN
done  out  1  high in DONE
status  out  2  00 none, 01 halt, 10 watchdog, 11 budget
cycle_cnt  out  CNT_W  number of enabled CPU cycles in the current or last run

Behaviour:
- Reset (rst=0, async): state = IDLE, cpu_rst=1, cpu_ce=0, busy=0, done=0, status=00, cycle_cnt=0, hold_cnt=0, stall_cnt=0, pc_q=0, step_req_d=0. Reset asserted mid-run aborts immediately, with no completion status.
- States: IDLE, HOLD, RUN, DONE. All registered; cpu_rst, busy, done and status decode from registers.
- IDLE: cpu_rst=1. start=1 moves to HOLD at the next edge and clears cycle_cnt, stall_cnt and status.
- HOLD: cpu_rst=1. hold_cnt counts 0..RST_HOLD-1; at hold_cnt=RST_HOLD-1 the state goes to RUN. cpu_rst is therefore high for exactly RST_HOLD cycles after the start edge. pc_q loads cpu_pc on the last HOLD cycle.
- RUN: cpu_rst=0.
  - cpu_ce is combinational: cpu_ce = (state==RUN) & (~mode | (step_req & ~step_req_d)).
  - mode may change in any cycle and takes effect in the same cycle.
  - A step_req held high gives only one enabled cycle. step_req_d is registered every cycle in every state.
- Per-edge updates in RUN when cpu_ce=1:
  - cycle_cnt += 1.
  - If cpu_pc==pc_q, stall_cnt += 1; otherwise stall_cnt = 0 and pc_q = cpu_pc.
  - Cycles with cpu_ce=0 change neither counter.
- Termination, evaluated every RUN edge, priority high to low:
  1. cpu_halt=1 (sampled even when cpu_ce=0) -> DONE, status 01.
  2. WDOG_CYCLES!=0 & cpu_ce & cpu_pc==pc_q & stall_cnt==WDOG_CYCLES-1 -> DONE, status 10.
  3. cpu_ce & cycle_cnt==MAX_CYCLES-1 -> DONE, status 11; cycle_cnt ends at exactly MAX_CYCLES.
  - cycle_cnt still increments on the terminating edge if cpu_ce=1. It never exceeds MAX_CYCLES.
- DONE: cpu_rst=0, cpu_ce=0, so CPU state is frozen for inspection. done=1; status and cycle_cnt hold.
  - start=1 -> HOLD, which clears status and counters as from IDLE.
  - start held high at DONE entry restarts on the following edge; this is intended auto-repeat.
- start is ignored in HOLD and RUN.

Decomposition:
- Shared defines file: state encodings (IDLE=2'd0, HOLD=2'd1, RUN=2'd2, DONE=2'd3) and status codes (ST_NONE, ST_HALT, ST_WDOG, ST_BUDGET). The CPU bench also uses these.
- One natural sub-module, pc_stall_wdog. It owns pc_q and stall_cnt, takes ce/pc/clear, and outputs the stall-trip flag. It is parameterised by PC_W and WDOG_CYCLES.

Test Plan:
- Reset and hold: rst low 3 cycles, release, start pulse with RST_HOLD=4 -> cpu_rst high exactly 4 cycles after the start edge, then 0; busy=1 throughout HOLD and RUN; all outputs at reset values while rst=0.
- Budget: MAX_CYCLES=10, mode=0, cpu_pc incrementing, cpu_halt=0 -> done=1 with status 11 and cycle_cnt=10; cpu_ce high for exactly 10 cycles.
- Halt priority: cpu_halt and budget boundary on the same edge (cycle_cnt=9, MAX=10) -> status 01, cycle_cnt=10.
- Watchdog: WDOG_CYCLES=4, cpu_pc stuck at 0x40 from cycle 5 -> status 10 after 4 stalled enabled cycles; WDOG_CYCLES=0 same stimulus -> ends on budget, status 11.
- Single-step: mode=1, step_req held high 5 cycles then two separate 1-cycle pulses -> cycle_cnt=3; stall_cnt unchanged during non-enabled cycles.
- Abort and restart: rst low mid-RUN at cycle_cnt=6 -> IDLE, cycle_cnt=0, cpu_rst=1; later start from DONE -> counters cleared, status 00 during the new run.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the CPU run controller: FSM states, termination codes
// and a small width helper used by the counters.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    ST_NONE   = 2'b00,
    ST_HALT   = 2'b01,
    ST_WDOG   = 2'b10,
    ST_BUDGET = 2'b11
  } run_status_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_wdog.sv
// PC-stall watchdog: tracks the last enabled-cycle PC and counts consecutive
// enabled cycles on which it did not change.
module pc_stall_wdog
  import cpu_run_ctrl_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int WDOG_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            load,
  input  logic            ce,
  input  logic [PC_W-1:0] pc,
  output logic            trip
);

  localparam int SW = cnt_width(WDOG_CYCLES + 1);
  localparam logic [SW-1:0] TRIP_AT = SW'((WDOG_CYCLES == 0) ? 0 : WDOG_CYCLES - 1);

  logic [PC_W-1:0] pc_q_r;
  logic [SW-1:0]   stall_cnt_r;
  logic            pc_match_s;

  // Trip on the enabled cycle that would make the stall run WDOG_CYCLES long.
  always_comb begin
    pc_match_s = (pc == pc_q_r);
    if ((WDOG_CYCLES != 0) && ce && pc_match_s && (stall_cnt_r == TRIP_AT)) begin
      trip = 1'b1;
    end else begin
      trip = 1'b0;
    end
  end

  // PC snapshot and stall counter; only enabled cycles advance them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q_r      <= '0;
      stall_cnt_r <= '0;
    end else if (clear) begin
      stall_cnt_r <= '0;
    end else if (load) begin
      pc_q_r <= pc;
    end else if (ce) begin
      if (pc_match_s) begin
        stall_cnt_r <= stall_cnt_r + SW'(1);
      end else begin
        stall_cnt_r <= '0;
        pc_q_r      <= pc;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU bring-up run controller: stretches the core reset, then runs it free or
// single-stepped until halt, PC-stall watchdog or cycle budget ends the run.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int RST_HOLD    = 4,
  parameter int MAX_CYCLES  = 1000,
  parameter int WDOG_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             step_req,
  input  logic             cpu_halt,
  input  logic [PC_W-1:0]  cpu_pc,
  output logic             cpu_rst,
  output logic             cpu_ce,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int HW = cnt_width(RST_HOLD);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

  run_state_e       state_r, state_nxt_s;
  run_status_e      status_r, status_nxt_s;
  logic [HW-1:0]    hold_cnt_r;
  logic [CNT_W-1:0] cycle_cnt_r;
  logic             step_req_d_r;
  logic             ce_s, trip_s, start_s, hold_last_s;

  // Enable qualification and run-start / reset-release strobes.
  always_comb begin
    ce_s        = (state_r == RUN) & (~mode | (step_req & ~step_req_d_r));
    start_s     = start & ((state_r == IDLE) | (state_r == DONE));
    hold_last_s = (state_r == HOLD) & (hold_cnt_r == HOLD_LAST);
  end

  pc_stall_wdog #(
    .PC_W        (PC_W),
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst),
    .clear (start_s),
    .load  (hold_last_s),
    .ce    (ce_s),
    .pc    (cpu_pc),
    .trip  (trip_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and termination cause; halt wins even on non-enabled cycles.
  always_comb begin
    state_nxt_s  = state_r;
    status_nxt_s = ST_NONE;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = HOLD;
        else       state_nxt_s = IDLE;
      end
      HOLD: begin
        if (hold_last_s) state_nxt_s = RUN;
        else             state_nxt_s = HOLD;
      end
      RUN: begin
        if (cpu_halt) begin
          state_nxt_s  = DONE;
          status_nxt_s = ST_HALT;
        end else if (trip_s) begin
          state_nxt_s  = DONE;
          status_nxt_s = ST_WDOG;
        end else if (ce_s && (cycle_cnt_r == CNT_LAST)) begin
          state_nxt_s  = DONE;
          status_nxt_s = ST_BUDGET;
        end else begin
          state_nxt_s  = RUN;
        end
      end
      DONE: begin
        if (start) state_nxt_s = HOLD;
        else       state_nxt_s = DONE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    cpu_rst = 1'b1;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_r)
      IDLE: begin
        cpu_rst = 1'b1;
      end
      HOLD: begin
        cpu_rst = 1'b1;
        busy    = 1'b1;
      end
      RUN: begin
        cpu_rst = 1'b0;
        busy    = 1'b1;
      end
      DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      default: begin
        cpu_rst = 1'b1;
      end
    endcase
  end

  // Hold counter, cycle counter, latched cause and step edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt_r   <= '0;
      cycle_cnt_r  <= '0;
      status_r     <= ST_NONE;
      step_req_d_r <= 1'b0;
    end else begin
      step_req_d_r <= step_req;
      if (state_r == HOLD) begin
        hold_cnt_r <= hold_cnt_r + HW'(1);
      end else begin
        hold_cnt_r <= '0;
      end
      if (start_s) begin
        cycle_cnt_r <= '0;
      end else if (ce_s) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (start_s) begin
        status_r <= ST_NONE;
      end else if ((state_r == RUN) && (state_nxt_s == DONE)) begin
        status_r <= status_nxt_s;
      end else begin
        status_r <= status_r;
      end
    end
  end

  assign cpu_ce    = ce_s;
  assign status    = status_r;
  assign cycle_cnt = cycle_cnt_r;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: two instances (watchdog 4 and watchdog off) share
// stimulus and are compared every cycle with a run-level reference model.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  localparam int PC_W = 32;
  localparam int CNT_W = 32;
  localparam int RH = 4;
  localparam int MAXC = 10;
  localparam logic [37:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0};

  logic clk = 1'b0;
  logic rst, start, mode, step_req, cpu_halt;
  logic [PC_W-1:0] cpu_pc;
  logic cpu_rst_a, cpu_ce_a, busy_a, done_a, cpu_rst_b, cpu_ce_b, busy_b, done_b;
  logic [1:0] status_a, status_b;
  logic [CNT_W-1:0] cycle_cnt_a, cycle_cnt_b;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: per instance, reset cycles left, run/finished flags, counts.
  bit m_active[2], m_fin[2];
  int m_rst_left[2], m_cycles[2], m_same[2];
  logic [PC_W-1:0] m_last_pc[2];
  logic [1:0] m_status[2];
  bit m_prev_step;

  cpu_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .RST_HOLD(RH), .MAX_CYCLES(MAXC), .WDOG_CYCLES(4)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .step_req(step_req), .cpu_halt(cpu_halt),
    .cpu_pc(cpu_pc), .cpu_rst(cpu_rst_a), .cpu_ce(cpu_ce_a), .busy(busy_a), .done(done_a),
    .status(status_a), .cycle_cnt(cycle_cnt_a));

  cpu_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .RST_HOLD(RH), .MAX_CYCLES(MAXC), .WDOG_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .step_req(step_req), .cpu_halt(cpu_halt),
    .cpu_pc(cpu_pc), .cpu_rst(cpu_rst_b), .cpu_ce(cpu_ce_b), .busy(busy_b), .done(done_b),
    .status(status_b), .cycle_cnt(cycle_cnt_b));

  always #5 clk = ~clk;

  function automatic int wd(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  function automatic bit m_ce(input int k);
    return m_active[k] && (m_rst_left[k] == 0) && (!mode || (step_req && !m_prev_step));
  endfunction

  function automatic logic [37:0] m_exp(input int k);
    bit in_reset;
    in_reset = !m_fin[k] && !(m_active[k] && (m_rst_left[k] == 0));
    return {in_reset, m_ce(k), m_active[k], m_fin[k], m_status[k], 32'(m_cycles[k])};
  endfunction

  function automatic logic [37:0] obs(input int k);
    if (k == 0) return {cpu_rst_a, cpu_ce_a, busy_a, done_a, status_a, cycle_cnt_a};
    else        return {cpu_rst_b, cpu_ce_b, busy_b, done_b, status_b, cycle_cnt_b};
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b0; m_fin[k] = 1'b0; m_rst_left[k] = 0;
      m_cycles[k] = 0; m_same[k] = 0; m_last_pc[k] = '0; m_status[k] = 2'b00;
    end
    m_prev_step = 1'b0;
  endtask

  task automatic m_finish(input int k, input logic [1:0] code);
    m_active[k] = 1'b0; m_fin[k] = 1'b1; m_status[k] = code;
  endtask

  task automatic m_edge();
    bit ce[2];
    bit stall, trip;
    for (int k = 0; k < 2; k++) ce[k] = m_ce(k);
    for (int k = 0; k < 2; k++) begin
      if (!m_active[k]) begin
        if (start) begin
          m_active[k] = 1'b1; m_fin[k] = 1'b0; m_rst_left[k] = RH;
          m_cycles[k] = 0; m_same[k] = 0; m_status[k] = 2'b00;
        end
      end else if (m_rst_left[k] > 0) begin
        m_rst_left[k]--;
        if (m_rst_left[k] == 0) m_last_pc[k] = cpu_pc;
      end else begin
        stall = ce[k] && (cpu_pc == m_last_pc[k]);
        trip  = (wd(k) != 0) && stall && (m_same[k] + 1 == wd(k));
        if (ce[k]) begin
          m_cycles[k]++;
          if (stall) m_same[k]++;
          else begin m_same[k] = 0; m_last_pc[k] = cpu_pc; end
        end
        if (cpu_halt)                            m_finish(k, 2'b01);
        else if (trip)                           m_finish(k, 2'b10);
        else if (ce[k] && (m_cycles[k] == MAXC)) m_finish(k, 2'b11);
      end
    end
    m_prev_step = step_req;
  endtask

  task automatic adv();
    @(posedge clk);
    if (!rst) m_reset();
    else      m_edge();
    #1;
  endtask

  task automatic settle();
    start = 1'b0; mode = 1'b0; step_req = 1'b0; cpu_halt = 1'b1;
    repeat (RH + 3) adv();
    cpu_halt = 1'b0;
  endtask

  task automatic test_reset();
    int nrst;
    rst = 1'b0; start = 1'b0; mode = 1'b0; step_req = 1'b0; cpu_halt = 1'b0; cpu_pc = '0;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1)); mode = 1'($urandom_range(0, 1)); step_req = 1'($urandom_range(0, 1));
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== RST_VEC) $display("FAIL reset_vals[%0d] got %h want %h", k, obs(k), RST_VEC);
        else n_pass++;
      end
    end
    @(negedge clk);
    start = 1'b0; mode = 1'b0; step_req = 1'b0; rst = 1'b1;
    adv();
    start = 1'b1; adv(); start = 1'b0;
    nrst = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== m_exp(k)) $display("FAIL hold[%0d] t=%0t got %h want %h", k, $time, obs(k), m_exp(k));
        else n_pass++;
      end
      if (!cpu_rst_a) break;
      nrst++;
      adv();
    end
    n_checks++;
    if (nrst !== RH) $display("FAIL hold_len got %0d want %0d", nrst, RH);
    else n_pass++;
  endtask

  task automatic test_budget();
    int ce_cnt = 0;
    logic [PC_W-1:0] pcv = 32'h0000_1000;
    settle();
    cpu_pc = pcv; start = 1'b1; adv(); start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pcv = pcv + 32'd4; cpu_pc = pcv;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== m_exp(k)) $display("FAIL budget[%0d] t=%0t got %h want %h", k, $time, obs(k), m_exp(k));
        else n_pass++;
      end
      if (cpu_ce_a) ce_cnt++;
      if (done_a && done_b) break;
      adv();
    end
    n_checks++;
    if ({status_a, cycle_cnt_a, status_b, cycle_cnt_b} !== {2'b11, 32'd10, 2'b11, 32'd10} || ce_cnt != 10)
      $display("FAIL budget_end got st=%b/%b cnt=%0d/%0d ce=%0d want 11/11 10/10 ce=10",
               status_a, status_b, cycle_cnt_a, cycle_cnt_b, ce_cnt);
    else n_pass++;
  endtask

  task automatic test_halt_priority();
    logic [PC_W-1:0] pcv = 32'h0000_2000;
    settle();
    cpu_pc = pcv; start = 1'b1; adv(); start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pcv = pcv + 32'd4; cpu_pc = pcv;
      cpu_halt = (m_cycles[0] == MAXC - 1);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== m_exp(k)) $display("FAIL halt_prio[%0d] t=%0t got %h want %h", k, $time, obs(k), m_exp(k));
        else n_pass++;
      end
      if (done_a && done_b) break;
      adv();
    end
    cpu_halt = 1'b0;
    n_checks++;
    if ({status_a, cycle_cnt_a, status_b, cycle_cnt_b} !== {2'b01, 32'd10, 2'b01, 32'd10})
      $display("FAIL halt_prio_end got st=%b/%b cnt=%0d/%0d want 01/01 10/10", status_a, status_b, cycle_cnt_a, cycle_cnt_b);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    settle();
    cpu_pc = 32'h0000_3000; start = 1'b1; adv(); start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cpu_pc = (m_cycles[0] < 4) ? 32'(32'h3000 + m_cycles[0] * 4) : 32'h0000_0040;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== m_exp(k)) $display("FAIL wdog[%0d] t=%0t got %h want %h", k, $time, obs(k), m_exp(k));
        else n_pass++;
      end
      if (done_a && done_b) break;
      adv();
    end
    n_checks++;
    if ({status_a, cycle_cnt_a, status_b, cycle_cnt_b} !== {2'b10, 32'd9, 2'b11, 32'd10})
      $display("FAIL wdog_end got st=%b/%b cnt=%0d/%0d want 10/11 9/10", status_a, status_b, cycle_cnt_a, cycle_cnt_b);
    else n_pass++;
  endtask

  task automatic test_single_step();
    logic [17:0] pat = 18'b0000_11111_00_1_00_1_000;
    settle();
    mode = 1'b1; cpu_pc = 32'h0000_0100; start = 1'b1; adv(); start = 1'b0;
    for (int i = 0; i < 19; i++) begin
      step_req = (i < 18) ? pat[17 - i] : 1'b0;
      cpu_halt = (i == 18);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== m_exp(k)) $display("FAIL step[%0d] t=%0t got %h want %h", k, $time, obs(k), m_exp(k));
        else n_pass++;
      end
      n_checks++;
      if (u_dut_a.u_wdog.stall_cnt_r !== 3'(m_same[0]))
        $display("FAIL step_stall got %0d want %0d", u_dut_a.u_wdog.stall_cnt_r, m_same[0]);
      else n_pass++;
      adv();
    end
    cpu_halt = 1'b0; mode = 1'b0;
    #1;
    n_checks++;
    if ({done_a, status_a, cycle_cnt_a} !== {1'b1, 2'b01, 32'd3})
      $display("FAIL step_end got done=%b st=%b cnt=%0d want 1 01 3", done_a, status_a, cycle_cnt_a);
    else n_pass++;
  endtask

  task automatic test_abort_restart();
    logic [PC_W-1:0] pcv = 32'h0000_4000;
    settle();
    cpu_pc = pcv; start = 1'b1; adv(); start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      pcv = pcv + 32'd4; cpu_pc = pcv;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== m_exp(k)) $display("FAIL abort_run[%0d] t=%0t got %h want %h", k, $time, obs(k), m_exp(k));
        else n_pass++;
      end
      adv();
      if (m_cycles[0] == 6) break;
    end
    #2 rst = 1'b0; m_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs(k) !== RST_VEC) $display("FAIL abort[%0d] got %h want %h", k, obs(k), RST_VEC);
      else n_pass++;
    end
    @(negedge clk) rst = 1'b1;
    adv();
    start = 1'b1; adv(); start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pcv = pcv + 32'd4; cpu_pc = pcv;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== m_exp(k)) $display("FAIL rerun[%0d] t=%0t got %h want %h", k, $time, obs(k), m_exp(k));
        else n_pass++;
      end
      if (done_a && done_b) break;
      adv();
    end
    start = 1'b1; adv();
    for (int i = 0; i < RH; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== m_exp(k)) $display("FAIL restart[%0d] t=%0t got %h want %h", k, $time, obs(k), m_exp(k));
        else n_pass++;
      end
      n_checks++;
      if ({status_a, cycle_cnt_a, busy_a} !== {2'b00, 32'd0, 1'b1})
        $display("FAIL restart_clr got st=%b cnt=%0d busy=%b want 00 0 1", status_a, cycle_cnt_a, busy_a);
      else n_pass++;
      adv();
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 63) != 0);
      if (!rst) m_reset();
      start    = ($urandom_range(0, 7) == 0);
      mode     = ($urandom_range(0, 2) == 0);
      step_req = 1'($urandom_range(0, 1));
      cpu_halt = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 0) cpu_pc = 32'(32'h10 + 4 * $urandom_range(0, 2));
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs(k) !== m_exp(k)) $display("FAIL random[%0d] t=%0t got %h want %h", k, $time, obs(k), m_exp(k));
        else n_pass++;
      end
      n_checks++;
      if (u_dut_a.u_wdog.stall_cnt_r !== 3'(m_same[0]))
        $display("FAIL random_stall got %0d want %0d", u_dut_a.u_wdog.stall_cnt_r, m_same[0]);
      else n_pass++;
      adv();
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_budget();
    test_halt_priority();
    test_watchdog();
    test_single_step();
    test_abort_restart();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
